// File: rtl/hamming_codec_sched.sv
// Two-requester sequencer around a shared Hamming(7,4) encode/inject/correct path.
// One word in flight: IDLE accepts, ENC corrects, OUT holds the result until accepted.
module hamming_codec_sched #(
  parameter bit RR    = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [3:0]       req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [3:0]       req1_data,
  output logic             req1_ready,
  input  logic [2:0]       inj_pos,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic [6:0]       out_code,
  output logic [2:0]       out_syndrome,
  output logic             out_corrected,
  output logic             out_src,
  output logic [CNT_W-1:0] cnt_words,
  output logic [CNT_W-1:0] cnt_corr
);

  typedef enum logic [1:0] {IDLE, ENC, OUT} state_t;

  state_t     state, next_state;
  logic       last_src;
  logic       src_q;
  logic [6:0] code_q;
  logic [2:0] inj_q;
  logic       handshake;
  logic [6:0] inj_mask;
  logic [6:0] rx_code;
  logic [2:0] syndrome;
  logic [3:0] fixed_data;

  function automatic logic [6:0] hamming_encode(input logic [3:0] d);
    return {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
  endfunction

  assign handshake = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (handshake) next_state = ENC;
      ENC:     next_state = OUT;
      OUT:     if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // On a tie, round-robin hands the grant to whoever was not served last.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    out_valid  = (state == OUT);
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        if (RR && !last_src) req1_ready = 1'b1;
        else                 req0_ready = 1'b1;
      end else begin
        req0_ready = req0_valid;
        req1_ready = req1_valid;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 7; i++) inj_mask[i] = (inj_q == 3'(i + 1));
  end

  assign rx_code = code_q ^ inj_mask;

  assign syndrome[0] = rx_code[0] ^ rx_code[2] ^ rx_code[4] ^ rx_code[6];
  assign syndrome[1] = rx_code[1] ^ rx_code[2] ^ rx_code[5] ^ rx_code[6];
  assign syndrome[2] = rx_code[3] ^ rx_code[4] ^ rx_code[5] ^ rx_code[6];

  // Only data-bit positions (3,5,6,7) matter for the corrected nibble.
  assign fixed_data[0] = rx_code[2] ^ (syndrome == 3'd3);
  assign fixed_data[1] = rx_code[4] ^ (syndrome == 3'd5);
  assign fixed_data[2] = rx_code[5] ^ (syndrome == 3'd6);
  assign fixed_data[3] = rx_code[6] ^ (syndrome == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_src      <= 1'b1;
      src_q         <= 1'b0;
      code_q        <= '0;
      inj_q         <= '0;
      out_data      <= '0;
      out_code      <= '0;
      out_syndrome  <= '0;
      out_corrected <= 1'b0;
      out_src       <= 1'b0;
      cnt_words     <= '0;
      cnt_corr      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (handshake) begin
            src_q  <= req1_ready;
            code_q <= hamming_encode(req1_ready ? req1_data : req0_data);
            inj_q  <= inj_pos;
          end
        end
        ENC: begin
          out_code      <= rx_code;
          out_syndrome  <= syndrome;
          out_corrected <= (syndrome != 3'd0);
          out_data      <= fixed_data;
          out_src       <= src_q;
        end
        OUT: begin
          if (out_ready) begin
            last_src <= out_src;
            if (cnt_words != '1) cnt_words <= cnt_words + CNT_W'(1);
            if (out_corrected && (cnt_corr != '1)) cnt_corr <= cnt_corr + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_codec_sched.sv
// Scoreboard bench for hamming_codec_sched: directed vectors, arbitration, stall, reset and sweep.
module tb_hamming_codec_sched;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             req0_valid, req1_valid;
  logic [3:0]       req0_data, req1_data;
  logic             req0_ready, req1_ready;
  logic [2:0]       inj_pos;
  logic             out_valid, out_ready;
  logic [3:0]       out_data;
  logic [6:0]       out_code;
  logic [2:0]       out_syndrome;
  logic             out_corrected, out_src;
  logic [CNT_W-1:0] cnt_words, cnt_corr;

  hamming_codec_sched #(.RR(1'b1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .inj_pos(inj_pos),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_code(out_code), .out_syndrome(out_syndrome),
    .out_corrected(out_corrected), .out_src(out_src),
    .cnt_words(cnt_words), .cnt_corr(cnt_corr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       src;
    logic [3:0] data;
    logic [6:0] code;
    logic [2:0] syn;
    logic       corr;
  } exp_t;

  typedef struct packed {
    logic       src;
    logic [3:0] din;
    logic [2:0] inj;
    logic [6:0] code;
    logic [2:0] syn;
    logic [3:0] dout;
    logic       corr;
  } vec_t;

  // Hand-computed codewords {d3,d2,d1,p4,d0,p2,p1} for data 0..15.
  logic [6:0] cw_table [16] = '{7'h00, 7'h07, 7'h19, 7'h1E, 7'h2A, 7'h2D, 7'h33, 7'h34,
                                7'h4B, 7'h4C, 7'h52, 7'h55, 7'h61, 7'h66, 7'h78, 7'h7F};

  vec_t vectors [5] = '{
    '{1'b0, 4'h5, 3'd0, 7'b0101101, 3'b000, 4'h5, 1'b0},
    '{1'b1, 4'h5, 3'd3, 7'b0101001, 3'b011, 4'h5, 1'b1},
    '{1'b0, 4'hD, 3'd7, 7'b0100110, 3'b111, 4'hD, 1'b1},
    '{1'b1, 4'h0, 3'd1, 7'b0000001, 3'b001, 4'h0, 1'b1},
    '{1'b0, 4'hF, 3'd4, 7'b1110111, 3'b100, 4'hF, 1'b1}
  };

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   mdl_words = 0;
  int   mdl_corr  = 0;
  logic tb_last_src = 1'b1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic exp_t mk_exp(input logic src, input logic [3:0] d, input logic [2:0] inj);
    exp_t e;
    logic [6:0] m;
    m = '0;
    if (inj != 3'd0) m[inj - 3'd1] = 1'b1;
    e.src  = src;
    e.data = d;
    e.code = cw_table[d] ^ m;
    e.syn  = inj;
    e.corr = (inj != 3'd0);
    return e;
  endfunction

  // Monitor: pops one expectation per output handshake and keeps the counter model.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checkOutput("sb_unexpected_output", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        checkOutput("out_data", out_data, mon_e.data);
        checkOutput("out_code", out_code, mon_e.code);
        checkOutput("out_syndrome", out_syndrome, mon_e.syn);
        checkOutput("out_corrected", out_corrected, mon_e.corr);
        checkOutput("out_src", out_src, mon_e.src);
        if (mdl_words < CNT_MAX) mdl_words++;
        if (mon_e.corr && mdl_corr < CNT_MAX) mdl_corr++;
      end
    end
  end

  task automatic applyStimulus(input logic src, input logic [3:0] din, input logic [2:0] inj,
                               input exp_t e, input bit push);
    int n;
    if (src) begin req1_valid = 1'b1; req1_data = din; end
    else     begin req0_valid = 1'b1; req0_data = din; end
    inj_pos = inj;
    #1;
    n = 0;
    while (!(src ? req1_ready : req0_ready) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) begin
      checkOutput("grant_timeout", 1, 0);
    end else begin
      if (push) sb_q.push_back(e);
      tb_last_src = src;
      @(posedge clk); #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    inj_pos    = 3'd0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) checkOutput("drain_timeout", 1, 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    int   gap;
    logic exp_src;

    rst = 1'b1; out_ready = 1'b1; inj_pos = 3'd0;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_data = 4'h0; req1_data = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_code", out_code, 0);
    checkOutput("rst_out_syndrome", out_syndrome, 0);
    checkOutput("rst_cnt_words", cnt_words, 0);
    checkOutput("rst_cnt_corr", cnt_corr, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors; the first also checks the two-edge latency.
    for (int i = 0; i < 5; i++) begin
      e = '{vectors[i].src, vectors[i].dout, vectors[i].code, vectors[i].syn, vectors[i].corr};
      applyStimulus(vectors[i].src, vectors[i].din, vectors[i].inj, e, 1'b1);
      if (i == 0) begin
        checkOutput("latency_enc_not_valid", out_valid, 0);
        @(posedge clk); #1;
        checkOutput("latency_out_valid", out_valid, 1);
      end
    end
    waitDrain();
    checkOutput("cnt_words_directed", cnt_words, mdl_words);
    checkOutput("cnt_corr_directed", cnt_corr, mdl_corr);

    // Downstream stall: outputs and counters frozen, no grants while in OUT.
    out_ready = 1'b0;
    e = '{1'b1, 4'hA, 7'h42, 3'd5, 1'b1};
    applyStimulus(1'b1, 4'hA, 3'd5, e, 1'b1);
    gap = 0;
    while (!out_valid && gap < 10) begin @(posedge clk); #1; gap++; end
    checkOutput("stall_reach_out", out_valid, 1);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      checkOutput("stall_valid", out_valid, 1);
      checkOutput("stall_readys", {req1_ready, req0_ready}, 2'b00);
      checkOutput("stall_code", out_code, 7'h42);
      checkOutput("stall_data", out_data, 4'hA);
      checkOutput("stall_cnt_words", cnt_words, mdl_words);
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    out_ready = 1'b1;
    waitDrain();
    checkOutput("cnt_words_after_stall", cnt_words, mdl_words);
    checkOutput("cnt_corr_after_stall", cnt_corr, mdl_corr);

    // Both requesters valid continuously: grants must alternate, one every 3 cycles.
    req0_data = 4'h3; req1_data = 4'hC; inj_pos = 3'd0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    gap = 0;
    for (int k = 0; k < 6; k++) begin
      while (!(req0_ready || req1_ready) && gap < 10) begin @(posedge clk); #1; gap++; end
      if (gap >= 10) begin
        checkOutput("rr_timeout", 1, 0);
        break;
      end
      exp_src = tb_last_src ? 1'b0 : 1'b1;
      checkOutput("rr_grant", {req1_ready, req0_ready}, exp_src ? 2'b10 : 2'b01);
      if (k > 0) checkOutput("rr_gap", gap, 3);
      sb_q.push_back(exp_src ? mk_exp(1'b1, 4'hC, 3'd0) : mk_exp(1'b0, 4'h3, 3'd0));
      tb_last_src = exp_src;
      @(posedge clk); #1;
      gap = 1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    waitDrain();

    // Reset while the word sits in ENC: word dropped, counters cleared.
    applyStimulus(1'b0, 4'h9, 3'd2, mk_exp(1'b0, 4'h9, 3'd2), 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mdl_words = 0; mdl_corr = 0; tb_last_src = 1'b1;
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_cnt_words", cnt_words, 0);
    checkOutput("midrst_cnt_corr", cnt_corr, 0);
    checkOutput("midrst_out_src", out_src, 0);
    @(posedge clk); #1;
    checkOutput("midrst_dropped", out_valid, 0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checkOutput("post_rst_tie_req0", {req1_ready, req0_ready}, 2'b01);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;

    // Full data x injection sweep; counters must saturate at all-ones.
    for (int d = 0; d < 16; d++) begin
      for (int p = 0; p < 8; p++) begin
        applyStimulus(1'((d + p) & 1), 4'(d), 3'(p), mk_exp(1'((d + p) & 1), 4'(d), 3'(p)), 1'b1);
      end
    end
    waitDrain();
    checkOutput("sweep_cnt_words_model", cnt_words, mdl_words);
    checkOutput("sweep_cnt_corr_model", cnt_corr, mdl_corr);
    checkOutput("sat_cnt_words", cnt_words, CNT_MAX);
    checkOutput("sat_cnt_corr", cnt_corr, CNT_MAX);
    checkOutput("sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
